shift_right_seq: RTL and testbench
==================================

# shift_right_seq

Sequential right-shift unit for the ALU datapath, the counterpart of the combinational left shifter. It accepts an operand and a shift amount on a start strobe. It shifts one bit position per clock, logical or arithmetic. It then presents the result with a one-cycle done pulse. It sits beside the other ALU function units and is driven by the ALU controller through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- AMT_W, 3, width of the shift-amount input; must be large enough to encode WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled on clk rising edge.
- arith  input  1  0 = logical shift (zero fill); 1 = arithmetic shift (sign fill from n1[WIDTH-1]).
- n1  input  WIDTH  operand; sampled with start.
- amount  input  AMT_W  shift distance; sampled with start.
- result  output  WIDTH  shifted value; holds its last completed value.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse when result is final.

## Operation
- One clock; reset is asynchronous and active-low.
- Internal state:
  - data register, WIDTH bits.
  - latched fill mode, 1 bit.
  - down-counter, AMT_W bits.
  - state machine: IDLE, SHIFT, DONE.
- IDLE, or DONE, with start=1:
  - data ← n1.
  - mode ← arith.
  - count ← min(amount, WIDTH).
  - next state is SHIFT.
- The load happens even when amount = 0.
- SHIFT with count ≠ 0:
  - data ← {fill, data[WIDTH-1:1]}.
  - fill = data[WIDTH-1] if mode = 1, else 0.
  - count decrements.
- SHIFT with count = 0: next state is DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - Without start, next state is IDLE.
  - With start, a new operation is loaded and the next state is SHIFT; back-to-back operations are allowed.
- start is ignored while in SHIFT; data, mode and count are not disturbed.
- Saturation: amount ≥ WIDTH shifts exactly WIDTH positions.
  - Logical result: all zeros.
  - Arithmetic result: all copies of the sign bit.
  - No wrap-around and no modulo on amount.
- result is driven from the data register.
  - It is only guaranteed meaningful when done = 1, and after done until the next start.
  - During SHIFT it shows intermediate values.
- busy = 1 exactly when the state is SHIFT.
- done is a registered output; busy and result are decoded or driven directly from registers; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: state IDLE, data 0, count 0, mode 0, result 0, busy 0, done 0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronous).
  - The in-flight operation is discarded.
  - No done pulse is produced for it.
- Start accepted at edge E0 with effective count k = min(amount, WIDTH):
  - busy is high from after E0 until after edge E0+k+1.
  - done is high for one cycle, after edge E0+k+1 until edge E0+k+2.
  - Latency from start to done is k+1 cycles: 1 cycle for amount 0, WIDTH+1 cycles at saturation.
- A start present at the edge that leaves DONE is accepted: done drops and busy rises on that same edge.
- Throughput: one operation per k+2 cycles when issued back-to-back.

## Test plan
- Logical, WIDTH=4: n1=4'b1011, amount=2, arith=0, start one cycle → busy for 3 cycles, then done pulse with result=4'b0010.
- Arithmetic: n1=4'b1011, amount=2, arith=1 → result=4'b1110, done 3 cycles after start.
- Zero and saturation:
  - amount=0, n1=4'b1011 → result=4'b1011, done 1 cycle after start.
  - amount=7, arith=0 → result=4'b0000 after 5 cycles.
  - amount=7, arith=1, n1=4'b1000 → result=4'b1111.
- Sweep: n1 = 0..15, amount=1, both modes, back-to-back starts issued in the DONE cycle.
  - Each result equals n1>>1 (logical) or n1>>>1 (arithmetic).
  - Exactly one done pulse per start.
- Protocol and reset:
  - start=1 with n1=4'b0110 while busy → ignored; the first operation completes unchanged.
  - rst_n pulsed low mid-SHIFT → result=0, busy=0, done=0 immediately, no done pulse afterwards.
  - A new start after reset operates normally.

Source files
------------

// File: rtl/shift_right_seq_if.sv
// Handshake and data bundle between the ALU controller and the sequential right shifter.
// Latency: none, wires only.
// Backpressure: none; the controller watches busy/done and only strobes start while the unit is idle or done.
interface shift_right_seq_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] n1;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  // Controller side: issues operations and observes completion.
  modport master (
    output start, arith, n1, amount,
    input  result, busy, done
  );

  // Shifter side: accepts operations and reports completion.
  modport slave (
    input  start, arith, n1, amount,
    output result, busy, done
  );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential logical/arithmetic right shifter, one bit position per clock.
// Latency: min(amount, WIDTH) + 1 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module shift_right_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_right_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Shift distances at or beyond WIDTH saturate to exactly WIDTH steps.
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             mode_q,  mode_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             done_q,  done_d;

  logic             fill;
  logic             busy_w;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Next-state decode: load from IDLE/DONE, shift until the counter runs out, then DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_SHIFT : S_IDLE;
      S_SHIFT: state_d = (count_q == '0) ? S_DONE : S_SHIFT;
      S_DONE:  state_d = bus.start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands on an accepted start, otherwise shift one position per SHIFT cycle.
  always_comb begin
    data_d  = data_q;
    mode_d  = mode_q;
    count_d = count_q;
    fill    = mode_q & data_q[WIDTH-1];
    // done is registered so it is asserted for exactly the cycle spent in DONE.
    done_d  = (state_q == S_SHIFT) && (count_q == '0);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          data_d  = bus.n1;
          mode_d  = bus.arith;
          count_d = (bus.amount >= WIDTH_AMT) ? WIDTH_AMT : bus.amount;
        end
      end
      S_SHIFT: begin
        if (count_q != '0) begin
          data_d  = {fill, data_q[WIDTH-1:1]};
          count_d = count_q - AMT_W'(1);
        end
      end
      default: begin
        data_d = data_q;
      end
    endcase
  end

  // Outputs come straight from registers; no input reaches an output combinationally.
  always_comb begin
    busy_w = (state_q == S_SHIFT);
  end

  assign bus.busy   = busy_w;
  assign bus.done   = done_q;
  assign bus.result = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for the sequential right shifter.
// Latency: checks start-to-done latency and busy length per operation.
// Backpressure: exercises start while busy and back-to-back starts in the done cycle.
module tb_shift_right_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_seen;

  shift_right_seq_if #(.WIDTH(4), .AMT_W(3)) bus ();

  shift_right_seq #(.WIDTH(4), .AMT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which done is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] n, input logic [2:0] amt, input logic ar);
    bus.start  = 1'b1;
    bus.n1     = n;
    bus.amount = amt;
    bus.arith  = ar;
    tick();
    bus.start  = 1'b0;
  endtask

  // Called just after the accepting edge; returns cycles until done and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cyc, output bit to);
    lat = 0;
    busy_cyc = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.arith = 1'b0; bus.n1 = '0; bus.amount = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.result !== 4'b0000) begin failures++; $display("FAIL reset_result got=%b exp=0000", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_logical();
    int lat, bc; bit to;
    issue(4'b1011, 3'd2, 1'b0);
    wait_done(lat, bc, to);
    checks++; if (to) begin failures++; $display("FAIL logical_timeout got=timeout exp=done"); end
    checks++; if (bus.result !== 4'b0010) begin failures++; $display("FAIL logical_result got=%b exp=0010", bus.result); end
    checks++; if (lat != 3) begin failures++; $display("FAIL logical_latency got=%0d exp=3", lat); end
    checks++; if (bc != 3) begin failures++; $display("FAIL logical_busy_cycles got=%0d exp=3", bc); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL logical_busy_at_done got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL logical_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 4'b0010) begin failures++; $display("FAIL logical_result_hold got=%b exp=0010", bus.result); end
  endtask

  task automatic test_arith();
    int lat, bc; bit to;
    issue(4'b1011, 3'd2, 1'b1);
    wait_done(lat, bc, to);
    checks++; if (to) begin failures++; $display("FAIL arith_timeout got=timeout exp=done"); end
    checks++; if (bus.result !== 4'b1110) begin failures++; $display("FAIL arith_result got=%b exp=1110", bus.result); end
    checks++; if (lat != 3) begin failures++; $display("FAIL arith_latency got=%0d exp=3", lat); end
    tick();
  endtask

  task automatic test_zero_and_saturate();
    int lat, bc; bit to;
    issue(4'b1011, 3'd0, 1'b1);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b1011) begin failures++; $display("FAIL zero_result got=%b exp=1011", bus.result); end
    checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    tick();
    issue(4'b1011, 3'd7, 1'b0);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b0000) begin failures++; $display("FAIL sat_logical_result got=%b exp=0000", bus.result); end
    checks++; if (lat != 5) begin failures++; $display("FAIL sat_logical_latency got=%0d exp=5", lat); end
    tick();
    issue(4'b1000, 3'd7, 1'b1);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b1111) begin failures++; $display("FAIL sat_arith_result got=%b exp=1111", bus.result); end
    checks++; if (lat != 5) begin failures++; $display("FAIL sat_arith_latency got=%0d exp=5", lat); end
    tick();
    issue(4'b1010, 3'd4, 1'b1);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b1111) begin failures++; $display("FAIL width_arith_result got=%b exp=1111", bus.result); end
    checks++; if (lat != 5) begin failures++; $display("FAIL width_arith_latency got=%0d exp=5", lat); end
    tick();
    issue(4'b0111, 3'd3, 1'b0);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b0000) begin failures++; $display("FAIL amt3_logical_result got=%b exp=0000", bus.result); end
    checks++; if (lat != 4) begin failures++; $display("FAIL amt3_logical_latency got=%0d exp=4", lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc, starts, base; bit to;
    logic [3:0] v, exp_v;
    logic ar;
    base = done_seen;
    starts = 0;
    issue(4'd0, 3'd1, 1'b0);
    starts++;
    for (int i = 0; i < 32; i++) begin
      v  = 4'(i % 16);
      ar = (i >= 16);
      exp_v = ar ? {v[3], v[3:1]} : {1'b0, v[3:1]};
      wait_done(lat, bc, to);
      checks++;
      if (to || bus.result !== exp_v || lat != 2) begin
        failures++;
        $display("FAIL b2b_op n1=%b arith=%b got=%b lat=%0d exp=%b lat=2", v, ar, bus.result, lat, exp_v);
      end
      if (i < 31) begin
        issue(4'((i + 1) % 16), 3'd1, (i + 1) >= 16);
        starts++;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_handoff idx=%0d got done=%b busy=%b exp done=0 busy=1", i, bus.done, bus.busy);
        end
      end
    end
    tick();
    tick();
    checks++;
    if (done_seen - base != starts) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=%0d", done_seen - base, starts);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc; bit to;
    issue(4'b1011, 3'd2, 1'b0);
    bus.start = 1'b1; bus.n1 = 4'b0110; bus.amount = 3'd0; bus.arith = 1'b1;
    wait_done(lat, bc, to);
    bus.start = 1'b0;
    checks++; if (to || bus.result !== 4'b0010) begin failures++; $display("FAIL busy_start_result got=%b exp=0010", bus.result); end
    checks++; if (lat != 3) begin failures++; $display("FAIL busy_start_latency got=%0d exp=3", lat); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL busy_start_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bc, base; bit to;
    issue(4'b1011, 3'd3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.result !== 4'b0000) begin failures++; $display("FAIL midrst_result got=%b exp=0000", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    #2;
    rst_n = 1'b1;
    base = done_seen;
    repeat (8) tick();
    checks++; if (done_seen != base) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen - base); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_idle_busy got=%b exp=0", bus.busy); end
    issue(4'b0110, 3'd1, 1'b1);
    wait_done(lat, bc, to);
    checks++; if (to || bus.result !== 4'b0011) begin failures++; $display("FAIL after_rst_result got=%b exp=0011", bus.result); end
    checks++; if (lat != 2) begin failures++; $display("FAIL after_rst_latency got=%0d exp=2", lat); end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_seen = 0;
    test_reset();
    test_logical();
    test_arith();
    test_zero_and_saturate();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
